// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory constants and the standard hex fontset image.
package chip8_pkg;

  localparam int CHIP8_ADDR_WIDTH = 12;
  localparam int CHIP8_DATA_WIDTH = 8;
  localparam int CHIP8_MEM_DEPTH  = 4096;
  localparam int FONT_BASE        = 'h000;
  localparam int FONT_BYTES       = 80;

  localparam logic [7:0] FONTSET [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

endpackage

// File: rtl/chip8_ram_if.sv
// Read handshake and write port of the CHIP-8 RAM.
interface chip8_ram_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);

  logic                  read;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_ack;
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output read, read_addr, write, write_addr, write_data,
    input  read_data, read_ack
  );

  modport slave (
    input  read, read_addr, write, write_addr, write_data,
    output read_data, read_ack
  );

endinterface

// File: rtl/chip8_fontset.sv
// Combinational power-up image lookup: fontset byte at FONT_BASE..FONT_BASE+79, zero elsewhere.
module chip8_fontset
  import chip8_pkg::*;
#(
  parameter int ADDR_WIDTH = CHIP8_ADDR_WIDTH,
  parameter int BASE       = FONT_BASE
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            font_byte
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(FONT_BYTES);

  logic [ADDR_WIDTH-1:0] offset;

  assign offset = addr - BASE_ADDR;

  always_comb begin
    font_byte = 8'h00;
    if (offset < SPAN) font_byte = FONTSET[offset[6:0]];
  end

endmodule

// File: rtl/chip8_ram.sv
// 4096x8 CHIP-8 RAM: one registered read port with ack, one write port, fontset at power-up.
module chip8_ram
  import chip8_pkg::*;
#(
  parameter int ADDR_WIDTH = CHIP8_ADDR_WIDTH,
  parameter int DATA_WIDTH = CHIP8_DATA_WIDTH,
  parameter int FONT_BASE  = chip8_pkg::FONT_BASE
) (
  input logic        clk,
  input logic        reset,
  chip8_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // The array holds each word XORed with its power-up image, so an all-zero
  // array reads back as the fontset without any load sequence.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [7:0]            font_rd;
  logic [7:0]            font_wr;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  read_ack_q;

  chip8_fontset #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(FONT_BASE)) u_font_rd (
    .addr      (bus.read_addr),
    .font_byte (font_rd)
  );

  chip8_fontset #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(FONT_BASE)) u_font_wr (
    .addr      (bus.write_addr),
    .font_byte (font_wr)
  );

  always_ff @(posedge clk) begin
    if (!reset && bus.write)
      mem[bus.write_addr] <= bus.write_data ^ DATA_WIDTH'(font_wr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_ack_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      read_ack_q <= bus.read;
      if (bus.read) read_data_q <= mem[bus.read_addr] ^ DATA_WIDTH'(font_rd);
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.read_ack  = read_ack_q;

endmodule

// File: tb/tb_chip8_ram.sv
// Directed bench for chip8_ram: fontset, fill/readback, streaming, collisions, reset.
module tb_chip8_ram;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  chip8_ram_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

  chip8_ram dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data);
    bus.write      = 1'b1;
    bus.write_addr = addr;
    bus.write_data = data;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [11:0] addr, input logic [7:0] exp);
    bus.read      = 1'b1;
    bus.read_addr = addr;
    tick();
    check({tag, "_ack"}, 32'(bus.read_ack), 32'd1);
    check({tag, "_data"}, 32'(bus.read_data), 32'(exp));
    bus.read = 1'b0;
    tick();
    check({tag, "_ack_drop"}, 32'(bus.read_ack), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.read       = 1'b0;
    bus.read_addr  = '0;
    bus.write      = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    tick();
    check("reset_ack", 32'(bus.read_ack), 32'd0);
    check("reset_data", 32'(bus.read_data), 32'd0);
    reset = 1'b0;
    tick();

    // Power-up fontset image
    do_read("font_000", 12'h000, 8'hF0);
    do_read("font_001", 12'h001, 8'h90);
    do_read("font_002", 12'h002, 8'h90);
    do_read("font_003", 12'h003, 8'h90);
    do_read("font_004", 12'h004, 8'hF0);
    do_read("font_04f", 12'h04F, 8'h80);
    do_read("font_050", 12'h050, 8'h00);

    // Write blocked by reset
    reset = 1'b1;
    do_write(12'hFFF, 8'hEE);
    check("wr_under_reset_ack", 32'(bus.read_ack), 32'd0);
    reset = 1'b0;
    tick();
    do_read("wr_under_reset", 12'hFFF, 8'h00);

    // Fill with i % 255, checking writes never raise ack
    for (int i = 0; i < 4096; i++) begin
      do_write(12'(i), 8'(i % 255));
      check("fill_ack", 32'(bus.read_ack), 32'd0);
      tick();
    end
    for (int i = 0; i < 4096; i++)
      do_read("readback", 12'(i), 8'(i % 255));

    // Back-to-back reads
    do_write(12'h200, 8'hA2);
    do_write(12'h201, 8'h2A);
    do_write(12'h202, 8'h60);
    bus.read      = 1'b1;
    bus.read_addr = 12'h200;
    tick();
    check("b2b0_ack", 32'(bus.read_ack), 32'd1);
    check("b2b0_data", 32'(bus.read_data), 32'hA2);
    bus.read_addr = 12'h201;
    tick();
    check("b2b1_ack", 32'(bus.read_ack), 32'd1);
    check("b2b1_data", 32'(bus.read_data), 32'h2A);
    bus.read_addr = 12'h202;
    tick();
    check("b2b2_ack", 32'(bus.read_ack), 32'd1);
    check("b2b2_data", 32'(bus.read_data), 32'h60);
    bus.read = 1'b0;
    tick();
    check("b2b_ack_drop", 32'(bus.read_ack), 32'd0);
    check("b2b_data_hold", 32'(bus.read_data), 32'h60);

    // Same-address collision: read-first
    do_write(12'h300, 8'h11);
    bus.read       = 1'b1;
    bus.read_addr  = 12'h300;
    bus.write      = 1'b1;
    bus.write_addr = 12'h300;
    bus.write_data = 8'h55;
    tick();
    check("collide_ack", 32'(bus.read_ack), 32'd1);
    check("collide_old", 32'(bus.read_data), 32'h11);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    tick();
    do_read("collide_new", 12'h300, 8'h55);

    // Different-address read and write on the same edge
    bus.read       = 1'b1;
    bus.read_addr  = 12'h201;
    bus.write      = 1'b1;
    bus.write_addr = 12'h202;
    bus.write_data = 8'h9C;
    tick();
    check("split_data", 32'(bus.read_data), 32'h2A);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    tick();
    do_read("split_written", 12'h202, 8'h9C);

    // Font-region overwrite stores the raw value
    do_write(12'h004, 8'h3C);
    do_read("font_overwrite", 12'h004, 8'h3C);

    // Reset mid-read clears outputs, keeps contents
    do_write(12'h123, 8'h7B);
    do_read("pre_reset", 12'h123, 8'h7B);
    bus.read      = 1'b1;
    bus.read_addr = 12'h123;
    reset         = 1'b1;
    tick();
    check("reset_read_ack", 32'(bus.read_ack), 32'd0);
    check("reset_read_data", 32'(bus.read_data), 32'd0);
    reset    = 1'b0;
    bus.read = 1'b0;
    tick();
    check("post_reset_idle_ack", 32'(bus.read_ack), 32'd0);
    do_read("retained", 12'h123, 8'h7B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
